// File: rtl/comm_autocal_pkg.sv
// comm_autocal_pkg: shared FSM encoding, PRBS7 constants and a width helper
// for the AD/DA link-training block.
package comm_autocal_pkg;

    typedef enum logic [2:0] {IDLE, SET, MEAS, NEXT, DONE} state_t;

    localparam logic [6:0] PRBS_SEED = 7'h7F;
    localparam logic [6:0] PRBS_TAPS = 7'h60;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/comm_autocal_chk.sv
// comm_autocal_chk: per-channel MSB compare, saturating error counter and
// best-select tracking across the delay sweep.
module comm_autocal_chk
    import comm_autocal_pkg::*;
#(
    parameter int SELW    = 4,
    parameter int WIN     = 64,
    parameter int ERR_MAX = 0,
    parameter int EW      = clog2(WIN) + 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            rx_bit,
    input  logic            ref_bit,
    input  logic            init,
    input  logic            clr,
    input  logic            meas,
    input  logic            upd,
    input  logic            fin,
    input  logic [SELW-1:0] cur_sel,
    output logic [EW-1:0]   best_err,
    output logic [SELW-1:0] best_sel,
    output logic            locked
);

    logic [EW-1:0]   err_q, err_d, best_err_q, best_err_d;
    logic [SELW-1:0] best_sel_q, best_sel_d;
    logic            locked_q, locked_d;
    logic            better;

    // strict less-than: on equal counts the earlier (lower) select is kept
    always_comb begin
        better     = err_q < best_err_q;
        err_d      = clr ? '0 :
                     (meas && rx_bit != ref_bit && err_q != EW'(WIN)) ? err_q + 1'b1 : err_q;
        best_err_d = init ? '1 : (upd && better) ? err_q : best_err_q;
        best_sel_d = init ? '0 : (upd && better) ? cur_sel : best_sel_q;
        locked_d   = init ? 1'b0 : fin ? (best_err_q <= EW'(ERR_MAX)) : locked_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q      <= '0;
            best_err_q <= '1;
            best_sel_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            err_q      <= err_d;
            best_err_q <= best_err_d;
            best_sel_q <= best_sel_d;
            locked_q   <= locked_d;
        end
    end

    assign best_err = best_err_q;
    assign best_sel = best_sel_q;
    assign locked   = locked_q;

endmodule

// File: rtl/comm_autocal.sv
// comm_autocal: drives PRBS7 on all DA channels, sweeps the AD delay select,
// keeps the lowest-error select per channel, then passes DA data through.
module comm_autocal
    import comm_autocal_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int DW      = 6,
    parameter int AW      = 8,
    parameter int SELW    = 4,
    parameter int SETTLE  = 24,
    parameter int WIN     = 64,
    parameter int REF_DLY = 4,
    parameter int ERR_MAX = 0,
    localparam int EW     = clog2(WIN) + 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [NCH*DW-1:0]   da_in,
    input  logic                da_valid_in,
    output logic [NCH*DW-1:0]   da_out,
    output logic                da_valid_out,
    output logic                tx_hold,
    input  logic [NCH*AW-1:0]   ad_dl,
    output logic [NCH*SELW-1:0] ad_sel,
    output logic                busy,
    output logic                done,
    output logic [NCH-1:0]      locked,
    output logic [NCH*EW-1:0]   best_err
);

    localparam int CW = clog2((SETTLE > WIN) ? SETTLE : WIN);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [6:0]        lfsr_q, lfsr_d;
    logic [REF_DLY-1:0] ref_q, ref_d;
    logic [NCH*DW-1:0] da_q;
    logic              dv_q;
    logic              train, prbs_bit, ref_bit, init;
    logic [SELW-1:0]   best_sel [NCH];
    logic              unused_ad;

    assign prbs_bit  = lfsr_q[6];
    assign ref_bit   = ref_q[REF_DLY-1];
    assign train     = state_q inside {SET, MEAS, NEXT};
    assign init      = state_q == IDLE && start;
    assign unused_ad = ^ad_dl;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        lfsr_d  = {lfsr_q[5:0], ^(lfsr_q & PRBS_TAPS)};
        ref_d   = REF_DLY'({ref_q, prbs_bit});
        case (state_q)
            IDLE: if (start) begin
                state_d = SET;
                cnt_d   = '0;
                sel_d   = '0;
            end
            SET: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(SETTLE - 1)) begin
                    state_d = MEAS;
                    cnt_d   = '0;
                end
            end
            MEAS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIN - 1)) begin
                    state_d = NEXT;
                    cnt_d   = '0;
                end
            end
            NEXT: begin
                state_d = (sel_q == '1) ? DONE : SET;
                sel_d   = sel_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            lfsr_q  <= PRBS_SEED;
            ref_q   <= '0;
            da_q    <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            lfsr_q  <= lfsr_d;
            ref_q   <= ref_d;
            da_q    <= da_in;
            dv_q    <= da_valid_in;
        end
    end

    // training owns the DA pins; sender data is simply not forwarded
    assign da_out       = train ? {(NCH*DW){prbs_bit}} : da_q;
    assign da_valid_out = train | dv_q;
    assign tx_hold      = train;
    assign busy         = train;
    assign done         = state_q == DONE;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        comm_autocal_chk #(
            .SELW(SELW), .WIN(WIN), .ERR_MAX(ERR_MAX), .EW(EW)
        ) u_chk (
            .CLK     (CLK),
            .RST     (RST),
            .rx_bit  (ad_dl[c*AW+AW-1]),
            .ref_bit (ref_bit),
            .init    (init),
            .clr     (state_q == SET),
            .meas    (state_q == MEAS),
            .upd     (state_q == NEXT),
            .fin     (state_q == DONE),
            .cur_sel (sel_q),
            .best_err(best_err[c*EW +: EW]),
            .best_sel(best_sel[c]),
            .locked  (locked[c])
        );
        assign ad_sel[c*SELW +: SELW] = train ? sel_q : best_sel[c];
    end

endmodule

// File: tb/tb_comm_autocal.sv
// tb_comm_autocal: randomized loopback bench; a delay-line model feeds DA back
// to AD and a recurrence-based PRBS7 model predicts every sweep result.
module tb_comm_autocal;

    localparam int NCH = 2, DW = 6, AW = 8, SELW = 4, SETTLE = 24, WIN = 64;
    localparam int REF_DLY = 4, ERR_MAX = 0, EW = 7;
    localparam int NSEL = 1 << SELW, BLK = SETTLE + WIN + 1, SWEEP = NSEL * BLK + 1;
    localparam int HLEN = 32768;

    logic                CLK = 1'b0, RST = 1'b1, start = 1'b0, da_valid_in = 1'b0;
    logic [NCH*DW-1:0]   da_in = '0, da_out;
    logic [NCH*AW-1:0]   ad_dl = '0;
    logic [NCH*SELW-1:0] ad_sel;
    logic [NCH-1:0]      locked;
    logic [NCH*EW-1:0]   best_err;
    logic                da_valid_out, tx_hold, busy, done;

    int n_vec = 0, n_err = 0;
    int cyc = 0, rst_cyc = 0;
    bit sq [HLEN];
    bit hist [NCH][HLEN];
    int dly [NCH][NSEL];
    bit stuck [NCH];

    comm_autocal #(
        .NCH(NCH), .DW(DW), .AW(AW), .SELW(SELW), .SETTLE(SETTLE),
        .WIN(WIN), .REF_DLY(REF_DLY), .ERR_MAX(ERR_MAX)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .da_in(da_in), .da_valid_in(da_valid_in),
        .da_out(da_out), .da_valid_out(da_valid_out), .tx_hold(tx_hold), .ad_dl(ad_dl),
        .ad_sel(ad_sel), .busy(busy), .done(done), .locked(locked), .best_err(best_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RST) rst_cyc <= cyc + 1;
    end

    function automatic bit prbs(input int n);
        return (n >= rst_cyc) ? sq[n - rst_cyc] : 1'b0;
    endfunction

    function automatic bit past(input int c, input int k);
        return (k >= 0) ? hist[c][k] : 1'b0;
    endfunction

    // delay-line model: AD MSB is the DA MSB from dly[c][sel] cycles ago
    always @(negedge CLK)
        for (int c = 0; c < NCH; c++) begin
            hist[c][cyc] = da_out[c*DW+DW-1];
            ad_dl[c*AW +: AW] = {~stuck[c] & past(c, cyc - dly[c][ad_sel[c*SELW +: SELW]]),
                                 (AW-1)'($urandom)};
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_dly(input int c, input int mask);
        int d;
        for (int s = 0; s < NSEL; s++) begin
            d = $urandom_range(0, 18);
            if (d >= REF_DLY) d++;
            dly[c][s] = mask[s] ? REF_DLY : d;
        end
    endtask

    task automatic run_cal(input bit disturb);
        int e0, n, bad, extra, e, best, bsel;
        bit rx;
        @(negedge CLK);
        start = 1'b1;
        e0 = cyc + 1;
        n = 0;
        bad = 0;
        extra = 0;
        do begin
            @(negedge CLK);
            n++;
            start = disturb && (n == 300 || done === 1'b1);
            if (n == 1) check("restart_sel0", ad_sel, 0);
            if (n == 1) check("busy_hold", {busy, tx_hold}, 2'b11);
            if (tx_hold && (da_out !== {(NCH*DW){prbs(cyc)}} || da_valid_out !== 1'b1)) bad++;
        end while (done !== 1'b1 && n < SWEEP + 50);
        check("sweep_len", n, SWEEP);
        check("da_prbs_bad", bad, 0);
        check("done_not_busy", busy, 0);
        @(negedge CLK);
        start = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            best = 1 << EW;
            bsel = 0;
            for (int s = 0; s < NSEL; s++) begin
                e = 0;
                for (int k = e0 + s*BLK + SETTLE; k < e0 + s*BLK + SETTLE + WIN; k++) begin
                    rx = stuck[c] ? 1'b0 : prbs(k - dly[c][s]);
                    e += int'(rx != prbs(k - REF_DLY));
                end
                if (e > WIN) e = WIN;
                if (e < best) begin
                    best = e;
                    bsel = s;
                end
            end
            check($sformatf("ad_sel[%0d]", c), ad_sel[c*SELW +: SELW], bsel);
            check($sformatf("best_err[%0d]", c), best_err[c*EW +: EW], best);
            check($sformatf("locked[%0d]", c), locked[c], best <= ERR_MAX);
        end
        repeat (100) begin
            @(negedge CLK);
            extra += int'(done) + int'(busy);
        end
        check("no_restart", extra, 0);
    endtask

    initial begin
        logic [NCH*DW-1:0] v;
        logic              vi;
        int                e0;
        for (int k = 0; k < HLEN; k++) sq[k] = (k < 7) ? 1'b1 : sq[k-6] ^ sq[k-7];
        for (int c = 0; c < NCH; c++) begin
            stuck[c] = 1'b0;
            set_dly(c, 0);
        end
        repeat (3) @(negedge CLK);
        check("rst_ctrl", {busy, done, tx_hold, da_valid_out}, 0);
        check("rst_sel", ad_sel, 0);
        check("rst_locked", locked, 0);
        check("rst_best_err", best_err, {(NCH*EW){1'b1}});
        check("rst_da_out", da_out, 0);
        RST = 1'b0;

        for (int i = 0; i < 6; i++) begin
            v  = (i == 0) ? 12'hABC : (NCH*DW)'($urandom);
            vi = (i == 0) ? 1'b1 : 1'($urandom);
            da_in = v;
            da_valid_in = vi;
            @(negedge CLK);
            check("pt_data", da_out, v);
            check("pt_valid", da_valid_out, vi);
            check("pt_hold", tx_hold, 0);
        end

        set_dly(0, 1 << 5);
        set_dly(1, 1 << 11);
        run_cal(1'b0);
        check("t1_sel", ad_sel, {4'd11, 4'd5});
        check("t1_locked", locked, 2'b11);
        check("t1_err", best_err, 0);

        set_dly(0, 1 << $urandom_range(0, NSEL - 1));
        stuck[1] = 1'b1;
        run_cal(1'b0);
        check("t2_unlocked", locked[1], 0);

        stuck[1] = 1'b0;
        set_dly(0, (1 << 3) | (1 << 4));
        set_dly(1, 1 << $urandom_range(0, NSEL - 1));
        run_cal(1'b0);
        check("t3_tie", ad_sel[SELW-1:0], 3);

        @(negedge CLK);
        start = 1'b1;
        e0 = cyc + 1;
        @(negedge CLK);
        start = 1'b0;
        while (cyc < e0 + 7*BLK + SETTLE + 20) @(negedge CLK);
        check("abort_in_meas7", ad_sel[SELW-1:0], 7);
        RST = 1'b1;
        @(negedge CLK);
        check("abort_ctrl", {busy, done, tx_hold}, 0);
        check("abort_sel", ad_sel, 0);
        check("abort_da_out", da_out, 0);
        RST = 1'b0;
        set_dly(0, 1 << $urandom_range(0, NSEL - 1));
        set_dly(1, 1 << $urandom_range(0, NSEL - 1));
        run_cal(1'b0);

        set_dly(0, 1 << $urandom_range(0, NSEL - 1));
        set_dly(1, 1 << $urandom_range(0, NSEL - 1));
        run_cal(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/comm_autocal.md
Name: comm_autocal

Overview:
- Parametrised link-training block for the AD/DA comm path, placed between the sender/receiver cores and the per-channel AD delay lines.
- On `start`, it drives a PRBS7 training pattern on every DA channel and sweeps the AD delay select over all values.
- For each channel it measures bit errors at each select value, keeps the best select, and reports the result.
- After training it passes DA data through unchanged and holds the selected delays, replacing manual delay setting.

Parameters:
- NCH, 2, number of DA/AD channel pairs
- DW, 6, DA sample width per channel
- AW, 8, AD sample width per channel
- SELW, 4, delay select width; sweep covers 0..2^SELW-1
- SETTLE, 24, cycles waited after a select change before measuring (must be >= max delay-line latency)
- WIN, 64, measurement window length in cycles
- REF_DLY, 4, fixed delay applied to the reference PRBS before comparison
- ERR_MAX, 0, largest best-case error count still accepted as locked

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous reset, active-high
- start  input  1  single-cycle pulse; begins training (ignored while busy)
- da_in  input  NCH*DW  data from sender, channel 0 in LSBs
- da_valid_in  input  1  sender DA valid
- da_out  output  NCH*DW  to DA pins
- da_valid_out  output  1  DA valid to pins/valid delay
- tx_hold  output  1  1 = sender must stall (training owns DA)
- ad_dl  input  NCH*AW  AD samples after external delay lines
- ad_sel  output  NCH*SELW  delay select per channel
- busy  output  1  training in progress
- done  output  1  single-cycle pulse at end of training
- locked  output  NCH  per channel: best error count <= ERR_MAX
- best_err  output  NCH*(clog2(WIN)+1)  per-channel best error count

Behaviour:
- Reset values:
  - FSM = IDLE; ad_sel = 0; locked = 0; best_err = all-ones; busy = 0; done = 0; tx_hold = 0.
  - LFSR = 7'h7F; da_out = 0; da_valid_out = 0.
- Pass-through (IDLE/DONE): da_out and da_valid_out are the registered da_in and da_valid_in, 1-cycle latency. tx_hold = 0.
- Training (SET, MEAS, NEXT):
  - tx_hold = 1 and da_valid_out = 1.
  - PRBS7 is x^7+x^6+1 and advances every cycle.
  - Every channel's da_out = {DW{prbs_bit}}, i.e. full-scale 0 or 2^DW-1.
- Comparison:
  - rx_bit[c] = ad_dl[c*AW+AW-1] (the MSB).
  - The reference is prbs_bit delayed by REF_DLY through a shift register.
  - A mismatch counts as an error.
- FSM:
  - IDLE: on start, go to SET. cur_sel = 0; all best_err = all-ones, best_sel = 0; busy = 1.
  - SET: ad_sel[c] = cur_sel for all c. Wait SETTLE cycles, then go to MEAS with error counters cleared.
  - MEAS: WIN cycles; each channel's error counter increments on mismatch and saturates at WIN. Then go to NEXT.
  - NEXT (1 cycle):
    - Per channel, if err < best_err, update best_err and best_sel. Strict less-than, so ties keep the lower select.
    - If cur_sel == 2^SELW-1, go to DONE; otherwise increment cur_sel and go to SET.
  - DONE (1 cycle):
    - ad_sel[c] = best_sel[c]; locked[c] = (best_err[c] <= ERR_MAX).
    - Pulse done; busy = 0; return to IDLE.
- Sweep length: exactly 2^SELW*(SETTLE+WIN+1)+1 cycles from start to done.
- start while busy: ignored. start in the same cycle as done: ignored.
- RST mid-training: returns to reset values immediately on the next edge.
- locked and best_err hold their values until the next start.
- da_in during training: dropped. The sender must honour tx_hold combinationally (tx_hold is a registered output).

Decomposition:
- Package comm_autocal_pkg holds:
  - FSM state enum (IDLE, SET, MEAS, NEXT, DONE)
  - PRBS7 polynomial/seed constants
  - a clog2 function for counter widths
- One sub-module: comm_autocal_chk, instanced NCH times. Per-channel contents:
  - MSB compare
  - saturating error counter
  - best_err/best_sel registers
  - NEXT-state update

Test Plan:
1. Loopback model with channel 0 delay line latency making sel=5 correct and channel 1 making sel=11 correct; pulse start -> done after 16*89+1=1425 cycles, ad_sel = {11,5}, locked = 2'b11, best_err = {0,0}.
2. Channel 1 AD stuck at 0 -> locked[1] = 0, best_err[1] about 32 (PRBS half ones), ad_sel[1] = lowest select with minimum error count.
3. Two selects both give 0 errors (e.g. 3 and 4) -> ad_sel = 3 (tie keeps lower).
4. Assert RST during MEAS of sel=7 -> next cycle busy = 0, ad_sel = 0, tx_hold = 0, da_out = 0; a new start restarts at sel=0.
5. Second start pulse while busy, and start coincident with done -> no restart; exactly one done pulse.
6. Idle pass-through: da_in = 12'hABC with da_valid_in = 1 -> da_out = 12'hABC and da_valid_out = 1 one cycle later; tx_hold stays 0.
